axil_req_arbiter: RTL
=====================

Name: axil_req_arbiter

Overview:
- Two-requester arbiter and sequencer for the four-register AXI4-Lite slave peripheral.
- Each requester issues single-word read/write commands on a simple valid/ready port. The block grants round-robin, runs exactly one AXI4-Lite transaction at a time as master, and returns data/response to the granted requester.
- Sits between local control logic and the peripheral's S00_AXI port, in the same clock/reset domain as the slave.

Parameters:
- ADDR_WIDTH, 4, AXI4-Lite byte-address width (4 registers x 4 bytes).
- DATA_WIDTH, 32, data width; only 32 supported.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset.
- cmd_valid  in  2  per-requester command valid; bit n = requester n.
- cmd_ready  out  2  per-requester accept pulse.
- cmd_we  in  2  1 = write, 0 = read, per requester.
- cmd_addr  in  2*ADDR_WIDTH  requester n at [n*ADDR_WIDTH +: ADDR_WIDTH].
- cmd_wdata  in  2*DATA_WIDTH  requester n at [n*DATA_WIDTH +: DATA_WIDTH].
- rsp_valid  out  2  one-cycle completion pulse to the granted requester.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP of the completed transaction.
- busy  out  1  high from grant until rsp_valid, inclusive.
- grant_id  out  1  index of the current/last granted requester.
- M_AXI_AWADDR/AWPROT/AWVALID  out  ADDR_WIDTH/3/1  write address channel; AWPROT = 0.
- M_AXI_AWREADY  in  1.
- M_AXI_WDATA/WSTRB/WVALID  out  DATA_WIDTH/4/1  write data channel; WSTRB = 4'hF.
- M_AXI_WREADY  in  1.
- M_AXI_BRESP/BVALID  in  2/1.
- M_AXI_BREADY  out  1.
- M_AXI_ARADDR/ARPROT/ARVALID  out  ADDR_WIDTH/3/1  read address channel; ARPROT = 0.
- M_AXI_ARREADY  in  1.
- M_AXI_RDATA/RRESP/RVALID  in  DATA_WIDTH/2/1.
- M_AXI_RREADY  out  1.

Behaviour:
Clock and reset:
- Single clock, ACLK.
- ARESET is synchronous and active-high.
- Reset values: every output 0, FSM in IDLE, round-robin pointer last_grant = 1 (so requester 0 wins first), grant_id = 0.

FSM states: IDLE, WR, WR_B, RD_A, RD_R, RESP.
- IDLE: if any cmd_valid is high, select a requester round-robin. Priority goes to the requester after last_grant; if only one is valid, it wins.
  - Same cycle: cmd_ready[g] = 1, latch addr/wdata/we, set grant_id = g, last_grant = g.
  - Next state: WR if we = 1, else RD_A.
- WR:
  - AWVALID and WVALID assert in the first WR cycle (grant cycle + 1).
  - Each drops independently in the cycle after its own handshake (VALID & READY sampled high).
  - Once both handshakes have completed, go to WR_B.
- WR_B: BREADY = 1. On BVALID, capture BRESP, set rdata = 0, go to RESP.
- RD_A: ARVALID = 1 until the ARREADY handshake, then go to RD_R.
- RD_R: RREADY = 1. On RVALID, capture RDATA and RRESP, go to RESP.
- RESP: rsp_valid[g] = 1 for exactly one cycle, with rsp_rdata and rsp_resp stable. Go to IDLE.
  - A new grant can occur in the IDLE cycle that follows.

Handshake and data rules:
- No VALID is ever deasserted before its READY.
- The AXI address is cmd_addr with bits [1:0] forced to 0.
- cmd_valid must stay high until cmd_ready. A command presented while busy waits and is not dropped.
- cmd_ready is never high for both requesters in the same cycle, and never high outside IDLE.
- rsp_* has no backpressure; the requester must accept it.
- SLVERR/DECERR responses pass through unchanged; they do not affect sequencing.

Latency:
- Best case, with readies held high and single-cycle slave responses: write is grant T, AW/W handshake at T+1, BVALID at T+2, rsp_valid at T+3. Read has the same timing.
- Minimum command-to-command spacing is 4 cycles.

Reset mid-operation:
- Any ARESET cycle returns the FSM to IDLE and clears all VALID/READY outputs the next edge.
- The in-flight command is abandoned; no rsp_valid is issued for it.
- The slave must share this reset.

Test Plan:
- Requester 0 writes 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC, then reads all four back -> rdata 0x1..0x4, rsp_resp = 0, each rsp_valid exactly 1 cycle.
- Both cmd_valid held high for 6 commands from reset -> grant_id sequence 0,1,0,1,0,1; cmd_ready is never 2'b11.
- Slave AWREADY delayed 3 cycles with WREADY immediate -> WVALID drops after 1 cycle, AWVALID holds 4 cycles, BREADY rises only after both handshakes, write lands correctly.
- Requester 1 reads address 0x6 -> ARADDR = 0x4, returns the register 1 value; requester 0 issues a write during the read -> it is held off until the IDLE after RESP.
- ARESET asserted in RD_R before RVALID -> all outputs 0 next cycle, no rsp_valid. After release, requester 0 wins first and a read of 0x0 completes.
- Slave returns BRESP = 2'b10 -> rsp_resp = 2'b10 to the granted requester, FSM returns to IDLE, next command proceeds normally.

Source files
------------

// File: rtl/axil_req_arbiter.sv
// Two-requester round-robin arbiter that sequences one AXI4-Lite transaction at a
// time against the four-register slave and returns the response to the granted requester.
module axil_req_arbiter #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [1:0]              cmd_valid,
   output logic [1:0]              cmd_ready,
   input  logic [1:0]              cmd_we,
   input  logic [2*ADDR_WIDTH-1:0] cmd_addr,
   input  logic [2*DATA_WIDTH-1:0] cmd_wdata,
   output logic [1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    busy,
   output logic                    grant_id,
   output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]              M_AXI_AWPROT,
   output logic                    M_AXI_AWVALID,
   input  logic                    M_AXI_AWREADY,
   output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                    M_AXI_WVALID,
   input  logic                    M_AXI_WREADY,
   input  logic [1:0]              M_AXI_BRESP,
   input  logic                    M_AXI_BVALID,
   output logic                    M_AXI_BREADY,
   output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]              M_AXI_ARPROT,
   output logic                    M_AXI_ARVALID,
   input  logic                    M_AXI_ARREADY,
   input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]              M_AXI_RRESP,
   input  logic                    M_AXI_RVALID,
   output logic                    M_AXI_RREADY
);

   typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, RESP} state_t;

   localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

   state_t                  state, state_nxt;
   logic                    last_grant;
   logic                    sel;
   logic                    grant;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_wdata;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic                    awvalid_q, wvalid_q;
   logic                    wr_done;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [1:0]              resp_q;

   // Requester after last_grant has priority; the other wins only when alone.
   always_comb begin
      sel = ~last_grant;
      if (!cmd_valid[~last_grant]) sel = last_grant;
      sel_addr  = sel ? cmd_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : cmd_addr[ADDR_WIDTH-1:0];
      sel_wdata = sel ? cmd_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : cmd_wdata[DATA_WIDTH-1:0];
   end

   assign grant   = (state == IDLE) && (cmd_valid != 2'b00) && !ARESET;
   assign wr_done = (!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY);

   always_comb begin
      state_nxt     = state;
      cmd_ready     = '0;
      rsp_valid     = '0;
      M_AXI_BREADY  = 1'b0;
      M_AXI_ARVALID = 1'b0;
      M_AXI_RREADY  = 1'b0;
      busy          = (state != IDLE) || grant;
      case (state)
         IDLE: begin
            if (grant) begin
               cmd_ready = 2'b01 << sel;
               state_nxt = cmd_we[sel] ? WR : RD_A;
            end
         end
         WR:   if (wr_done) state_nxt = WR_B;
         WR_B: begin
            M_AXI_BREADY = 1'b1;
            if (M_AXI_BVALID) state_nxt = RESP;
         end
         RD_A: begin
            M_AXI_ARVALID = 1'b1;
            if (M_AXI_ARREADY) state_nxt = RD_R;
         end
         RD_R: begin
            M_AXI_RREADY = 1'b1;
            if (M_AXI_RVALID) state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 2'b01 << grant_id;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         grant_id   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         rdata_q    <= '0;
         resp_q     <= '0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            last_grant <= sel;
            grant_id   <= sel;
            addr_q     <= sel_addr & WORD_MASK;
            wdata_q    <= sel_wdata;
            awvalid_q  <= cmd_we[sel];
            wvalid_q   <= cmd_we[sel];
         end
         // AW and W retire independently; each drops the cycle after its own handshake.
         if (awvalid_q && M_AXI_AWREADY) awvalid_q <= 1'b0;
         if (wvalid_q && M_AXI_WREADY) wvalid_q <= 1'b0;
         if (state == WR_B && M_AXI_BVALID) begin
            resp_q  <= M_AXI_BRESP;
            rdata_q <= '0;
         end
         if (state == RD_R && M_AXI_RVALID) begin
            resp_q  <= M_AXI_RRESP;
            rdata_q <= M_AXI_RDATA;
         end
      end
   end

   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWPROT  = '0;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARPROT  = '0;
   assign rsp_rdata     = rdata_q;
   assign rsp_resp      = resp_q;

endmodule
